// File: rtl/ds_pkg.sv
// rtl/ds_pkg.sv - shared encodings and lane-select helpers for the banked data store
package ds_pkg;

  typedef enum logic [1:0] {
    MODE_FULL = 2'b00,
    MODE_BYTE = 2'b01,
    MODE_HALF = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Width of the in-row offset field handed to the helpers (covers up to 256 lanes).
  localparam int LOW_W = 8;

  // Misaligned or reserved access; low holds the in-row byte offset.
  function automatic logic req_error(input mode_t mode, input logic [LOW_W-1:0] low);
    case (mode)
      MODE_FULL: return |low;
      MODE_HALF: return low[0];
      MODE_BYTE: return 1'b0;
      default:   return 1'b1;
    endcase
  endfunction

  // Whether a lane participates in an access at the given in-row byte offset.
  function automatic logic lane_selected(input mode_t mode, input int lane, input int offset);
    case (mode)
      MODE_FULL: return 1'b1;
      MODE_BYTE: return lane == offset;
      MODE_HALF: return (lane >> 1) == (offset >> 1);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ds_lane.sv
// rtl/ds_lane.sv - one byte lane: ROWS x 8 RAM, one write port, main and debug read ports
module ds_lane #(
  parameter int ROWS = 1024,
  parameter int RW   = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [RW-1:0] raddr,
  output logic [7:0]    rdata,
  input  logic [RW-1:0] daddr,
  output logic [7:0]    ddata
);

  logic [7:0] mem [ROWS];

  // Synchronous write; contents are only meaningful after the clear sweep.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
  assign ddata = mem[daddr];

endmodule

// File: rtl/ds_banked.sv
// rtl/ds_banked.sv - byte-lane banked data store with clear sweep and aligned sub-word access
module ds_banked
  import ds_pkg::*;
#(
  parameter int AWIDTH = 12,
  parameter int LANES  = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_mode,
  input  logic                 req_signed,
  input  logic [AWIDTH-1:0]    req_addr,
  input  logic [8*LANES-1:0]   req_wdata,
  output logic                 rsp_valid,
  output logic [8*LANES-1:0]   rsp_rdata,
  output logic                 rsp_err,
  input  logic [AWIDTH-1:0]    dbg_addr,
  output logic [8*LANES-1:0]   dbg_rdata,
  output logic                 init_busy
);

  localparam int LB     = $clog2(LANES);
  localparam int DWIDTH = 8 * LANES;
  localparam int ROWS   = (2 ** AWIDTH) / LANES;
  localparam int RW     = AWIDTH - LB;

  state_t            state, state_next;
  logic [RW-1:0]     cnt;
  logic              clearing;
  logic              accept;
  logic              err;
  mode_t             mode;
  int                offset;
  logic [RW-1:0]     row;
  logic [RW-1:0]     dbg_row;
  logic [DWIDTH-1:0] rd_row;
  logic [DWIDTH-1:0] load_data;
  logic [15:0]       half_v;
  logic [7:0]        byte_v;
  logic              unused_dbg_low;

  assign mode           = mode_t'(req_mode);
  assign offset         = int'(req_addr[LB-1:0]);
  assign row            = req_addr[AWIDTH-1:LB];
  assign dbg_row        = dbg_addr[AWIDTH-1:LB];
  assign unused_dbg_low = ^dbg_addr[LB-1:0];
  assign err            = req_error(mode, LOW_W'(req_addr[LB-1:0]));
  assign accept         = req_valid & req_ready;

  // State register and sweep row counter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (clearing) cnt <= cnt + RW'(1);
    end
  end

  // Next state and handshake outputs: sweep every row once, then serve requests.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    init_busy  = 1'b0;
    clearing   = 1'b0;
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        clearing  = 1'b1;
        if (cnt == RW'(ROWS - 1)) state_next = ST_RUN;
      end
      ST_RUN:  req_ready = 1'b1;
      default: state_next = ST_INIT;
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic       sel;
    logic       we;
    logic [7:0] wd;
    logic [7:0] rd;
    logic [7:0] dd;

    assign sel = lane_selected(mode, i, offset);
    assign we  = clearing | (accept & req_we & ~err & sel);
    assign wd  = clearing            ? 8'h00 :
                 (mode == MODE_FULL) ? req_wdata[8*i +: 8] :
                 (mode == MODE_HALF) ? req_wdata[8*(i%2) +: 8] :
                                       req_wdata[7:0];

    ds_lane #(.ROWS(ROWS), .RW(RW)) u_lane (
      .clk   (clk),
      .we    (we),
      .waddr (clearing ? cnt : row),
      .wdata (wd),
      .raddr (row),
      .rdata (rd),
      .daddr (dbg_row),
      .ddata (dd)
    );

    assign rd_row[8*i +: 8]    = rd;
    assign dbg_rdata[8*i +: 8] = dd;
  end

  // Pick the addressed bytes out of the row, move them to the LSBs and extend.
  always_comb begin
    load_data = '0;
    half_v    = rd_row[16*(offset/2) +: 16];
    byte_v    = rd_row[8*offset +: 8];
    case (mode)
      MODE_FULL: load_data = rd_row;
      MODE_HALF: load_data = req_signed ? DWIDTH'($signed(half_v)) : DWIDTH'(half_v);
      MODE_BYTE: load_data = req_signed ? DWIDTH'($signed(byte_v)) : DWIDTH'(byte_v);
      default:   load_data = '0;
    endcase
  end

  // Registered one-cycle response; clr drops any response in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept & err;
      rsp_rdata <= (accept & ~req_we & ~err) ? load_data : '0;
    end
  end

endmodule

// File: doc/ds_banked.md
DS_BANKED -- requirements
Module: ds_banked

Interface
REQ-001 SHALL have parameter AWIDTH, default 12, byte-address width.
REQ-002 SHALL have parameter LANES, default 4, bytes per row (power of two, at least 2); DWIDTH = 8*LANES; ROWS = 2**AWIDTH/LANES.
REQ-003 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port clr, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, request accepted this cycle if req_valid is also high.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_mode, input, 2, 00 = full row, 01 = byte, 10 = half, 11 = reserved.
REQ-009 SHALL have port req_signed, input, 1, load extension: 1 = sign, 0 = zero.
REQ-010 SHALL have port req_addr, input, AWIDTH, byte address.
REQ-011 SHALL have port req_wdata, input, DWIDTH, store data, LSB-aligned.
REQ-012 SHALL have port rsp_valid, output, 1, one-cycle response strobe.
REQ-013 SHALL have port rsp_rdata, output, DWIDTH, load result; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1, misaligned or reserved-mode request, qualified by rsp_valid.
REQ-015 SHALL have port dbg_addr, input, AWIDTH, debug read byte address; low log2(LANES) bits ignored.
REQ-016 SHALL have port dbg_rdata, output, DWIDTH, combinational full-row read at dbg_addr.
REQ-017 SHALL have port init_busy, output, 1, high while the clear sweep runs.

Function
REQ-018 SHALL implement FSM states INIT and RUN; clr forces INIT with row counter 0.
REQ-019 SHALL, in INIT, zero one row per cycle at the counter, then enter RUN after row ROWS-1 (ROWS cycles); req_ready=0 and init_busy=1 throughout.
REQ-020 SHALL, in RUN, drive req_ready=1 every cycle; back-to-back requests at one per cycle with no bubbles.
REQ-021 SHALL assert rsp_valid for exactly one cycle, the cycle after each accepted request; rsp_rdata and rsp_err are registered.
REQ-022 SHALL select lanes as follows: full row = all lanes; half = lanes 2k and 2k+1, k = addr[log2(LANES)-1:1]; byte = lane addr[log2(LANES)-1:0].
REQ-023 SHALL flag an error when half has addr[0]=1, full row has any nonzero low log2(LANES) bit, or mode=11; an erroring store writes nothing.
REQ-024 SHALL, on a store, write the LSB bytes of req_wdata into the selected lanes at the accept edge; unselected lanes are unchanged.
REQ-025 SHALL, on a load, return the selected bytes shifted to the LSB, extended to DWIDTH per req_signed.
REQ-026 SHALL return store data to a load accepted the cycle after a store to the same row.
REQ-027 SHALL update dbg_rdata after the write edge; dbg reads never stall requests.
REQ-028 SHALL, on clr mid-operation, discard any pending response (rsp_valid=0 immediately) and restart the sweep at row 0.
REQ-029 SHALL ignore requests presented while req_ready=0; they produce no response and cause no state change.

Reset
REQ-030 SHALL, while clr=1: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, init_busy=1; memory contents undefined until the sweep completes.

Structure
REQ-031 SHALL take the mode encodings, FSM state encoding and lane-select helper constants from shared package ds_pkg.
REQ-032 SHALL instantiate LANES copies of sub-module ds_lane: one 8-bit x ROWS byte RAM with write enable, main read port and debug read port.

Verification
REQ-033 Bench SHALL check the sweep: release clr -> init_busy=1 for 1024 cycles (defaults), req_ready rises next; every row of dbg_rdata reads 0.
REQ-034 Bench SHALL check a byte store then loads: store byte 0xA5 at 0x006; signed byte load 0x006 -> 0xFFFFFFA5; unsigned -> 0x000000A5; full-row load 0x004 -> 0x00A50000.
REQ-035 Bench SHALL check a half store then load: store half 0x8001 at 0x00A, then signed half load -> 0xFFFF8001; lanes 0-1 of row 0x008 unchanged.
REQ-036 Bench SHALL check misalignment: half store at 0x003 and full-row load at 0x002 -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-037 Bench SHALL check back-to-back access: store 0x12345678 at 0x010, then load 0x010 next cycle -> 0x12345678 one cycle later.
REQ-038 Bench SHALL check clr mid-operation: assert clr in the cycle after a load is accepted -> no rsp_valid, and the sweep reruns from row 0.
